yankee_solver: RTL and testbench
================================

# yankee_solver

Sequential quadratic evaluator: y = a·x² + b·x + c over signed operands. It sits between an operand source and a result consumer and talks to both through a start/ready/valid handshake. It uses one shared 16-bit multiplier and one adder under a small FSM, so one evaluation completes in a fixed number of clock cycles.

## Interface
- No parameters.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces the idle state immediately.
- x  input  8  signed abscissa, two's complement.
- a  input  16  signed quadratic coefficient.
- b  input  16  signed linear coefficient.
- c  input  16  signed constant term.
- enable  input  1  start request; sampled on the rising clock edge.
- y  output  16  signed result, two's complement.
- ready  output  1  block is idle and will accept enable.
- valid  output  1  y holds the result of the most recent evaluation.
- Positional port order: clock, x, a, b, c, enable, reset, y, ready, valid.
- One clock; reset is asynchronous and active-high.

## Operation
- FSM states: IDLE, MUL_XX, MUL_AXX, MUL_BX, SUM, then back to IDLE.
- IDLE:
  - ready=1.
  - On a rising edge with enable=1, latch x, a, b, c into internal registers, clear valid and ready, and go to MUL_XX.
  - With enable=0, stay in IDLE.
- MUL_XX: p ← sext16(x)·sext16(x), keep the low 16 bits.
- MUL_AXX: p ← a·p, keep the low 16 bits.
- MUL_BX: q ← b·sext16(x), keep the low 16 bits.
- SUM: y ← p + q + c, keep the low 16 bits; set valid=1 and ready=1; go to IDLE.
- Arithmetic is modulo 2^16 throughout, with no saturation. The result is exactly (a·x² + b·x + c) mod 2^16, read as signed.
- Operands are used only from the latched copies. Input changes after the capture edge do not affect the running evaluation.
- enable while not in IDLE is ignored. It is not queued.
- y and valid hold their values in IDLE until the next accepted enable. That enable clears valid on the capture edge, so every evaluation produces a fresh 0→1 edge on valid. y keeps its old value until SUM.
- Reset in any state, including mid-evaluation: state=IDLE, y=0, valid=0, ready=1, internal registers cleared. The aborted evaluation never asserts valid.

## Timing
- Reset values: y=16'h0000, valid=0, ready=1.
- Capture edge E0 is the rising edge where IDLE sees enable=1. After E0: ready=0, valid=0.
- MUL_XX, MUL_AXX, MUL_BX and SUM occupy edges E1 to E4.
- After E4, y is updated and valid=1, ready=1; both change on the same edge.
- Latency from capture edge to valid: 4 cycles.
- Minimum spacing between captures: 5 cycles, since the next enable can be accepted at E5.
- A one-cycle enable pulse is sufficient. enable held high in IDLE after completion starts a new evaluation on the next edge.
- Outputs are registered, with no combinational path from inputs to y, ready or valid.

## Test plan
- Reset:
  - Assert reset for 5 cycles with no clock edge needed → y=0, valid=0, ready=1.
  - Release reset → outputs unchanged, state IDLE.
- Basic evaluation:
  - x=2, a=1, b=2, c=3, one-cycle enable → ready low at E0; y=11, valid=1, ready=1 after E4.
  - Then x=-3, a=2, b=-5, c=7 → y=40, with valid showing a fresh 0→1 edge.
- Edge values:
  - x=0, a=100, b=-100, c=-32768 → y=-32768.
  - x=-128, a=1, b=1, c=0 → y=16256.
- Wrap-around: x=127, a=4, b=0, c=0 → y=-1020 (64516 mod 2^16).
- Busy protection:
  - Pulse enable again at E2 with different operands → ignored; y equals the first evaluation's result at E4.
  - Next enable in IDLE → uses the new operands.
- Reset mid-operation: assert reset at E2 → immediate y=0, valid=0, ready=1; no valid pulse follows.

Source files
------------

// File: rtl/yankee_solver.sv
// Sequential quadratic evaluator: y = a*x^2 + b*x + c (mod 2^16, signed).
// A single shared 16-bit multiplier and one adder are sequenced by a small FSM.
// One evaluation takes four cycles after the capture edge.
module yankee_solver (
  input  logic        clock,
  input  logic [7:0]  x,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic        enable,
  input  logic        reset,
  output logic [15:0] y,
  output logic        ready,
  output logic        valid
);

  typedef enum logic [2:0] {
    StIdle,
    StMulXx,
    StMulAxx,
    StMulBx,
    StSum
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] c_q, c_d;
  logic [15:0] p_q, p_d;
  logic [15:0] q_q, q_d;
  logic [15:0] y_q, y_d;
  logic        valid_q, valid_d;

  logic [15:0] x_ext;
  logic [15:0] mul_a, mul_b, mul_p;

  assign x_ext = {{8{x_q[7]}}, x_q};

  // Shared multiplier operand select; only the low 16 bits of the product are
  // kept, which are the same for signed and unsigned operands.
  always_comb begin
    mul_a = x_ext;
    mul_b = x_ext;
    case (state_q)
      StMulAxx: begin
        mul_a = a_q;
        mul_b = p_q;
      end
      StMulBx: begin
        mul_a = b_q;
        mul_b = x_ext;
      end
      default: ;
    endcase
    mul_p = mul_a * mul_b;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    p_d     = p_q;
    q_d     = q_q;
    y_d     = y_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        if (enable) begin
          x_d     = x;
          a_d     = a;
          b_d     = b;
          c_d     = c;
          valid_d = 1'b0;
          state_d = StMulXx;
        end
      end
      StMulXx: begin
        p_d     = mul_p;
        state_d = StMulAxx;
      end
      StMulAxx: begin
        p_d     = mul_p;
        state_d = StMulBx;
      end
      StMulBx: begin
        q_d     = mul_p;
        state_d = StSum;
      end
      StSum: begin
        y_d     = p_q + q_q + c_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any evaluation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      p_q     <= p_d;
      q_q     <= q_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  // ready is decoded from the state register alone, so it is glitch-free and
  // has no path from the inputs.
  assign ready = (state_q == StIdle);
  assign y     = y_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_yankee_solver.sv
// Self-checking bench for yankee_solver: directed cases from the datasheet
// followed by randomized evaluations checked against an arithmetic model.
module tb_yankee_solver;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  x = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] c = '0;
  logic        enable = 1'b0;
  logic [15:0] y;
  logic        ready;
  logic        valid;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  yankee_solver dut (
    .clock  (clock),
    .x      (x),
    .a      (a),
    .b      (b),
    .c      (c),
    .enable (enable),
    .reset  (reset),
    .y      (y),
    .ready  (ready),
    .valid  (valid)
  );

  // Reference: plain integer polynomial, reduced mod 2^16.
  function automatic logic [15:0] model(input logic [7:0] xv, input logic [15:0] av,
                                        input logic [15:0] bv, input logic [15:0] cv);
    longint xs, as, bs, cs, r;
    xs = longint'($signed(xv));
    as = longint'($signed(av));
    bs = longint'($signed(bv));
    cs = longint'($signed(cv));
    r  = as * xs * xs + bs * xs + cs;
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] xv, input logic [15:0] av,
                       input logic [15:0] bv, input logic [15:0] cv);
    x = xv;
    a = av;
    b = bv;
    c = cv;
  endtask

  // One-cycle enable pulse, scramble inputs after capture, check the whole
  // handshake and the result after E4.
  task automatic eval_check(input string tag, input logic [7:0] xv, input logic [15:0] av,
                            input logic [15:0] bv, input logic [15:0] cv,
                            input logic [15:0] exp);
    @(negedge clock);
    drive(xv, av, bv, cv);
    enable = 1'b1;
    @(negedge clock);  // after E0
    enable = 1'b0;
    drive(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    chk({tag, "_e0_ready"}, 16'(ready), 16'd0);
    chk({tag, "_e0_valid"}, 16'(valid), 16'd0);
    repeat (3) @(negedge clock);  // after E3
    chk({tag, "_e3_valid"}, 16'(valid), 16'd0);
    @(negedge clock);  // after E4
    chk({tag, "_y"}, y, exp);
    chk({tag, "_valid"}, 16'(valid), 16'd1);
    chk({tag, "_ready"}, 16'(ready), 16'd1);
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_async_y", y, 16'h0000);
    chk("rst_async_valid", 16'(valid), 16'd0);
    chk("rst_async_ready", 16'(ready), 16'd1);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_rel_y", y, 16'h0000);
    chk("rst_rel_valid", 16'(valid), 16'd0);
    chk("rst_rel_ready", 16'(ready), 16'd1);

    // Directed evaluations with hand-computed results.
    eval_check("basic1", 8'd2, 16'd1, 16'd2, 16'd3, 16'd11);
    eval_check("basic2", -8'sd3, 16'd2, -16'sd5, 16'd7, 16'd40);
    eval_check("zero_x", 8'd0, 16'd100, -16'sd100, 16'h8000, 16'h8000);
    eval_check("min_x", 8'h80, 16'd1, 16'd1, 16'd0, 16'd16256);
    eval_check("wrap", 8'd127, 16'd4, 16'd0, 16'd0, 16'hFC04);

    // Busy protection: a second enable at E2 is dropped.
    @(negedge clock);
    drive(8'd5, 16'd3, 16'd7, 16'd1);
    enable = 1'b1;
    @(negedge clock);  // after E0
    enable = 1'b0;
    @(negedge clock);  // after E1
    drive(8'd9, 16'd11, -16'sd2, 16'd100);
    enable = 1'b1;
    @(negedge clock);  // after E2
    enable = 1'b0;
    @(negedge clock);  // after E3
    @(negedge clock);  // after E4
    chk("busy_y", y, 16'd111);
    chk("busy_valid", 16'(valid), 16'd1);
    @(negedge clock);
    chk("busy_no_restart", 16'(ready), 16'd1);
    eval_check("after_busy", 8'd9, 16'd11, -16'sd2, 16'd100, model(8'd9, 16'd11, -16'sd2, 16'd100));

    // enable held high across completion restarts on the very next edge.
    @(negedge clock);
    drive(-8'sd7, 16'd3, 16'd4, 16'd5);
    enable = 1'b1;
    repeat (5) @(negedge clock);  // after E4
    chk("hold_y", y, model(-8'sd7, 16'd3, 16'd4, 16'd5));
    chk("hold_ready_e4", 16'(ready), 16'd1);
    @(negedge clock);  // after E5
    chk("hold_ready_e5", 16'(ready), 16'd0);
    chk("hold_valid_e5", 16'(valid), 16'd0);
    enable = 1'b0;
    repeat (4) @(negedge clock);
    chk("hold_y2", y, model(-8'sd7, 16'd3, 16'd4, 16'd5));
    chk("hold_valid2", 16'(valid), 16'd1);

    // Reset in the middle of an evaluation.
    @(negedge clock);
    drive(8'd10, 16'd10, 16'd10, 16'd10);
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);  // E1
    @(posedge clock);  // E2
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_y", y, 16'h0000);
    chk("mid_rst_valid", 16'(valid), 16'd0);
    chk("mid_rst_ready", 16'(ready), 16'd1);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("mid_rst_no_valid", 16'(valid), 16'd0);
    end

    // Randomized evaluations.
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  rx;
      logic [15:0] ra, rb, rc;
      rx = 8'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 16'($urandom);
      eval_check("rand", rx, ra, rb, rc, model(rx, ra, rb, rc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
